// File: rtl/axis_split_copy_buffered.sv
// AXI-Stream split-copy: one input stream is duplicated to OUTPUTS streams, each
// behind its own DEPTH-entry FIFO, with a per-output enable mask latched at frame start.
module axis_split_copy_buffered #(
  parameter int DATA_WIDTH = 64,
  parameter int OUTPUTS    = 2,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         dataIn_data,
  input  logic                          dataIn_last,
  input  logic                          dataIn_valid,
  output logic                          dataIn_ready,
  input  logic [OUTPUTS-1:0]            out_en,
  output logic [OUTPUTS*DATA_WIDTH-1:0] dataOut_data,
  output logic [OUTPUTS-1:0]            dataOut_last,
  output logic [OUTPUTS-1:0]            dataOut_valid,
  input  logic [OUTPUTS-1:0]            dataOut_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshake: a beat moves on any port only in a cycle where valid and ready are
  // both high at the rising edge; valid never waits on ready.

  logic               in_frame_q, in_frame_d;
  logic [OUTPUTS-1:0] mask_q, mask_d;
  logic [OUTPUTS-1:0] active_mask;
  logic [OUTPUTS-1:0] room;
  logic [OUTPUTS-1:0] push;
  logic [OUTPUTS-1:0] pop;
  logic               accept;

  assign active_mask  = in_frame_q ? mask_q : out_en;
  // Ready looks only at registered counts, so a full FIFO blocks even while popping.
  assign dataIn_ready = !rst && (&(~active_mask | room));
  assign accept       = dataIn_valid && dataIn_ready;
  assign push         = active_mask & {OUTPUTS{accept}};

  always_comb begin
    in_frame_d = in_frame_q;
    mask_d     = mask_q;
    if (accept) begin
      if (!in_frame_q) mask_d = out_en;
      in_frame_d = !dataIn_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame_q <= 1'b0;
      mask_q     <= '0;
    end else begin
      in_frame_q <= in_frame_d;
      mask_q     <= mask_d;
    end
  end

  for (genvar g = 0; g < OUTPUTS; g++) begin : g_fifo
    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;

    assign room[g]          = (count_q < FULL);
    assign dataOut_valid[g] = (count_q != '0);
    assign pop[g]           = dataOut_valid[g] && dataOut_ready[g];

    assign dataOut_data[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign dataOut_last[g]                          = mem_q[rd_ptr_q][DATA_WIDTH];

    always_comb begin
      count_d = count_q;
      case ({push[g], pop[g]})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Pointers wrap by natural overflow because DEPTH is a power of two.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        count_q <= count_d;
        if (push[g]) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop[g])  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push[g]) mem_q[wr_ptr_q] <= {dataIn_last, dataIn_data};
    end
  end

endmodule

// File: tb/tb_axis_split_copy_buffered.sv
// Bench for axis_split_copy_buffered: directed scenarios plus random traffic, checked
// against a queue-per-output reference model of the split-copy behaviour.
module tb_axis_split_copy_buffered;

  localparam int DW    = 64;
  localparam int NOUT  = 2;
  localparam int DEPTH = 4;

  logic               clk;
  logic               rst;
  logic [DW-1:0]      dataIn_data;
  logic               dataIn_last;
  logic               dataIn_valid;
  logic               dataIn_ready;
  logic [NOUT-1:0]    out_en;
  logic [NOUT*DW-1:0] dataOut_data;
  logic [NOUT-1:0]    dataOut_last;
  logic [NOUT-1:0]    dataOut_valid;
  logic [NOUT-1:0]    dataOut_ready;

  axis_split_copy_buffered #(
    .DATA_WIDTH(DW),
    .OUTPUTS   (NOUT),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dataIn_data  (dataIn_data),
    .dataIn_last  (dataIn_last),
    .dataIn_valid (dataIn_valid),
    .dataIn_ready (dataIn_ready),
    .out_en       (out_en),
    .dataOut_data (dataOut_data),
    .dataOut_last (dataOut_last),
    .dataOut_valid(dataOut_valid),
    .dataOut_ready(dataOut_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected contents of each output, {last, data}
  logic [DW:0]     exp_q0[$];
  logic [DW:0]     exp_q1[$];
  logic            m_in_frame;
  logic [NOUT-1:0] m_mask;
  int              pass_cnt;
  int              total_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      pass_cnt++;
  endtask

  // One cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                      input logic [NOUT-1:0] en, input logic [NOUT-1:0] ordy,
                      input logic r, output logic acc);
    logic [NOUT-1:0] act;
    logic            exp_rdy;
    @(negedge clk);
    rst           = r;
    dataIn_valid  = v;
    dataIn_data   = d;
    dataIn_last   = l;
    out_en        = en;
    dataOut_ready = ordy;
    #1;
    act     = m_in_frame ? m_mask : en;
    exp_rdy = !r && (!act[0] || exp_q0.size() < DEPTH) && (!act[1] || exp_q1.size() < DEPTH);
    check("in_ready", 64'(dataIn_ready), 64'(exp_rdy));
    check("out0_valid", 64'(dataOut_valid[0]), 64'(exp_q0.size() != 0));
    check("out1_valid", 64'(dataOut_valid[1]), 64'(exp_q1.size() != 0));
    if (exp_q0.size() != 0) begin
      check("out0_data", dataOut_data[DW-1:0], exp_q0[0][DW-1:0]);
      check("out0_last", 64'(dataOut_last[0]), 64'(exp_q0[0][DW]));
    end
    if (exp_q1.size() != 0) begin
      check("out1_data", dataOut_data[2*DW-1:DW], exp_q1[0][DW-1:0]);
      check("out1_last", 64'(dataOut_last[1]), 64'(exp_q1[0][DW]));
    end
    acc = v && exp_rdy;
    if (r) begin
      exp_q0.delete();
      exp_q1.delete();
      m_in_frame = 1'b0;
      m_mask     = '0;
    end else begin
      if (exp_q0.size() != 0 && ordy[0]) void'(exp_q0.pop_front());
      if (exp_q1.size() != 0 && ordy[1]) void'(exp_q1.pop_front());
      if (acc) begin
        if (act[0]) exp_q0.push_back({l, d});
        if (act[1]) exp_q1.push_back({l, d});
        if (!m_in_frame) m_mask = en;
        m_in_frame = !l;
      end
    end
  endtask

  // driver: hold one beat until accepted, bounded
  task automatic send(input logic [DW-1:0] d, input logic l,
                      input logic [NOUT-1:0] en, input logic [NOUT-1:0] ordy);
    logic acc;
    int   n;
    n = 0;
    do begin
      step(1'b1, d, l, en, ordy, 1'b0, acc);
      n++;
    end while (!acc && n < 32);
    check("send_accept", 64'(acc), 64'(1));
  endtask

  task automatic idle(input int cycles, input logic [NOUT-1:0] en, input logic [NOUT-1:0] ordy);
    logic acc;
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b0, en, ordy, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    pass_cnt      = 0;
    total_cnt     = 0;
    m_in_frame    = 1'b0;
    m_mask        = '0;
    rst           = 1'b1;
    dataIn_valid  = 1'b0;
    dataIn_data   = '0;
    dataIn_last   = 1'b0;
    out_en        = '0;
    dataOut_ready = '0;
    repeat (2) @(posedge clk);

    // 1: both outputs, one 3-beat frame
    send(64'h11, 1'b0, 2'b11, 2'b11);
    send(64'h22, 1'b0, 2'b11, 2'b11);
    send(64'h33, 1'b1, 2'b11, 2'b11);
    idle(3, 2'b11, 2'b11);

    // 2: output 1 stalled until its FIFO fills, then released
    for (int i = 1; i <= 4; i++) send(64'(i), 1'b0, 2'b11, 2'b01);
    for (int i = 0; i < 3; i++) step(1'b1, 64'h5, 1'b0, 2'b11, 2'b01, 1'b0, acc);
    send(64'h5, 1'b0, 2'b11, 2'b11);
    send(64'h6, 1'b1, 2'b11, 2'b11);
    idle(6, 2'b11, 2'b11);

    // 3: mask latched at frame start
    send(64'hA0, 1'b0, 2'b01, 2'b11);
    send(64'hA1, 1'b0, 2'b11, 2'b11);
    send(64'hA2, 1'b1, 2'b11, 2'b11);
    send(64'hB0, 1'b0, 2'b11, 2'b11);
    send(64'hB1, 1'b1, 2'b11, 2'b11);
    idle(3, 2'b11, 2'b11);

    // 4: all outputs disabled, beats discarded at full rate
    send(64'hAA, 1'b0, 2'b00, 2'b11);
    send(64'hBB, 1'b1, 2'b00, 2'b11);
    idle(2, 2'b00, 2'b11);

    // 5: full FIFO blocks input in the cycle it is popped
    for (int i = 0; i < 4; i++) send(64'hC0 + 64'(i), 1'b0, 2'b01, 2'b00);
    step(1'b1, 64'hC4, 1'b0, 2'b01, 2'b01, 1'b0, acc);
    send(64'hC4, 1'b1, 2'b01, 2'b01);
    idle(6, 2'b01, 2'b11);

    // 6: reset mid-frame drops buffered beats
    send(64'hD0, 1'b0, 2'b11, 2'b00);
    send(64'hD1, 1'b0, 2'b11, 2'b00);
    step(1'b1, 64'hD2, 1'b0, 2'b11, 2'b00, 1'b1, acc);
    send(64'h55, 1'b1, 2'b10, 2'b00);
    idle(2, 2'b11, 2'b00);
    idle(3, 2'b11, 2'b11);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
           1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 99) == 0), acc);
    end
    idle(10, 2'b11, 2'b11);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
